temp: RTL and testbench

TEMP -- requirements
Module: temp

---
 rtl/temp.sv | 68 ++++++
 tb/tb_temp.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/temp.sv
// Token-only circular buffer: counts tokens in and out, carries no payload.
// Latency: a token pushed at edge N is offered downstream in the cycle after edge N.
// Backpressure: ready_o drops when all DEPTH slots are occupied; both handshakes come from registered count only.
module temp #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic arst_n,
    input  logic valid_i,
    output logic ready_o,
    output logic valid_o,
    input  logic ready_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Last slot index and the full occupancy value, sized to their registers.
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Handshake flags depend only on the count register, so neither ready
    // nor valid has a combinational path from the opposite side's input.
    assign ready_o = (count != CNT_FULL);
    assign valid_o = (count != '0);

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    // Write pointer: advance on push, wrap by explicit compare so any DEPTH works.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
        end
    end

    // Read pointer: advance on pop, same explicit wrap.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy: a simultaneous push and pop cancel out; push is already
    // gated by full and pop by empty, so the count cannot leave 0..DEPTH.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_temp.sv
module tb_temp;

    localparam int DEPTH = 4;

    logic clk;
    logic arst_n;
    logic valid_i;
    logic ready_o;
    logic valid_o;
    logic ready_i;

    int tests_run;
    int tests_failed;

    // Reference model: a queue of token ids plus running push/pop totals.
    int q[$];
    int next_id;
    int push_total;
    int pop_total;
    bit model_known;

    temp #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge compare the DUT against the model,
    // apply new inputs, advance the model as the rising edge will, then wait for it.
    task automatic cycle(input logic v, input logic r, input logic rst_n);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        if (model_known) begin
            chk("ready_o", {31'd0, ready_o}, (q.size() != DEPTH) ? 32'd1 : 32'd0);
            chk("valid_o", {31'd0, valid_o}, (q.size() != 0) ? 32'd1 : 32'd0);
            chk("count",   32'(dut.count),  32'(q.size()));
            chk("wr_ptr",  32'(dut.wr_ptr), 32'(push_total % DEPTH));
            chk("rd_ptr",  32'(dut.rd_ptr), 32'(pop_total % DEPTH));
        end
        valid_i = v;
        ready_i = r;
        arst_n  = rst_n;
        if (!rst_n) begin
            q.delete();
            push_total  = 0;
            pop_total   = 0;
            model_known = 1'b1;
        end else begin
            do_push = v && (q.size() < DEPTH);
            do_pop  = r && (q.size() > 0);
            if (do_pop) begin
                void'(q.pop_front());
                pop_total++;
            end
            if (do_push) begin
                q.push_back(next_id);
                next_id++;
                push_total++;
            end
            if (pop_total > push_total) begin
                tests_run++;
                tests_failed++;
                $error("FAIL model_order pops=%0d pushes=%0d", pop_total, push_total);
            end
        end
        @(posedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        next_id      = 0;
        push_total   = 0;
        pop_total    = 0;
        model_known  = 1'b0;
        valid_i      = 1'b0;
        ready_i      = 1'b0;
        arst_n       = 1'b0;

        // Reset, including input activity that must be ignored.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Single token: push once, valid for exactly one cycle, then empty.
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);

        // Fill with extra offers that must be ignored once full.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1);

        // Drain from full.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1);

        // Full plus ready_i: pop only while full, push lands the cycle after.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);

        // Steady stream from empty: pointers wrap repeatedly.
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b1);

        // Mid-operation reset with two tokens stored.
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic rv;
            logic rr;
            logic rn;
            rv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 3) != 0 ? (i % 64 < 32 ? 1 : $urandom_range(0, 1)) : 0);
            rn = ($urandom_range(0, 59) != 0);
            cycle(rv, rr, rn);
        end

        // Final settle and check.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
